// File: rtl/alu_console_pkg.sv
// Shared opcodes and FSM state encodings for the push-button ALU console.
package alu_console_pkg;

  localparam logic [5:0] OP_ADD = 6'b100000;
  localparam logic [5:0] OP_SUB = 6'b100010;
  localparam logic [5:0] OP_AND = 6'b100100;
  localparam logic [5:0] OP_OR  = 6'b100101;
  localparam logic [5:0] OP_XOR = 6'b100110;
  localparam logic [5:0] OP_NOR = 6'b100111;
  localparam logic [5:0] OP_SRA = 6'b000011;
  localparam logic [5:0] OP_SRL = 6'b000010;

  typedef enum logic [1:0] {
    S_A   = 2'd0,
    S_B   = 2'd1,
    S_OP  = 2'd2,
    S_RES = 2'd3
  } state_t;

endpackage

// File: rtl/alu_console_btn_conditioner.sv
// Raw button conditioner: 2-FF synchroniser, debounce counter, and a
// one-cycle pulse on each accepted rising level.
module btn_conditioner #(
  parameter int DEBOUNCE_CYCLES = 1000000
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_btn,
  output logic o_level,
  output logic o_pulse
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [1:0]    sync_reg;
  logic [CW-1:0] count_reg;
  logic          level_reg;
  logic          pulse_reg;

  // The count only advances while the synced input disagrees with the
  // accepted level; any agreement (a bounce) restarts it from zero.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      sync_reg  <= '0;
      count_reg <= '0;
      level_reg <= 1'b0;
      pulse_reg <= 1'b0;
    end else begin
      sync_reg  <= {sync_reg[0], i_btn};
      pulse_reg <= 1'b0;
      if (sync_reg[1] == level_reg) begin
        count_reg <= '0;
      end else if (count_reg == LAST) begin
        level_reg <= sync_reg[1];
        count_reg <= '0;
        pulse_reg <= sync_reg[1];
      end else begin
        count_reg <= count_reg + CW'(1);
      end
    end
  end

  assign o_level = level_reg;
  assign o_pulse = pulse_reg;

endmodule

// File: rtl/alu_console.sv
// Board-level ALU console: debounced buttons sequence A, B and opcode loads;
// result and status flags are registered for stable LED display.
module alu_console
  import alu_console_pkg::*;
#(
  parameter int OPERAND_SIZE    = 8,
  parameter int OP_CODE_SIZE    = 6,
  parameter int DEBOUNCE_CYCLES = 1000000
) (
  input  logic                    i_clk,
  input  logic                    i_rst_n,
  input  logic [OPERAND_SIZE-1:0] i_switches,
  input  logic                    i_btn_A,
  input  logic                    i_btn_B,
  input  logic                    i_btn_OP,
  output logic [OPERAND_SIZE:0]   o_resultado,
  output logic                    o_zero,
  output logic                    o_ovf,
  output logic                    o_inv_op,
  output logic                    o_seq_err,
  output logic [1:0]              o_state
);

  localparam int N = OPERAND_SIZE;

  // Button index: 0 = A, 1 = B, 2 = OP
  logic [2:0] btn_raw;
  logic [2:0] level;
  logic [2:0] pulse;
  logic [2:0] press;

  assign btn_raw = {i_btn_OP, i_btn_B, i_btn_A};

  generate
    for (genvar gi = 0; gi < 3; gi++) begin : g_btn
      btn_conditioner #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
      ) u_cond (
        .i_clk  (i_clk),
        .i_rst_n(i_rst_n),
        .i_btn  (btn_raw[gi]),
        .o_level(level[gi]),
        .o_pulse(pulse[gi])
      );
      // A pulse is only ever issued together with a high stable level.
      assign press[gi] = pulse[gi] & level[gi];
    end
  endgenerate

  state_t       state_reg, state_next;
  logic [N-1:0] a_reg, a_next;
  logic [N-1:0] b_reg, b_next;
  logic [N:0]   res_reg, res_next;
  logic         zero_reg, zero_next;
  logic         ovf_reg, ovf_next;
  logic         inv_reg, inv_next;
  logic         seq_reg, seq_next;

  logic [OP_CODE_SIZE-1:0] op_sw;
  logic [N:0]              sum;
  logic [N:0]              diff;
  logic                    shift_big;
  logic [N:0]              alu_res;
  logic                    alu_ovf;
  logic                    alu_inv;

  assign op_sw     = i_switches[OP_CODE_SIZE-1:0];
  assign sum       = {1'b0, a_reg} + {1'b0, b_reg};
  assign diff      = {1'b0, a_reg} - {1'b0, b_reg};
  assign shift_big = 32'(b_reg) >= 32'(N);

  // The ALU sees the opcode straight from the switches; its result is only
  // captured on the edge that accepts the OP pulse.
  always_comb begin
    alu_res = '0;
    alu_ovf = 1'b0;
    alu_inv = 1'b0;
    case (op_sw)
      OP_CODE_SIZE'(OP_ADD): begin
        alu_res = sum;
        alu_ovf = (a_reg[N-1] == b_reg[N-1]) && (sum[N-1] != a_reg[N-1]);
      end
      OP_CODE_SIZE'(OP_SUB): begin
        alu_res = diff;
        alu_ovf = (a_reg[N-1] != b_reg[N-1]) && (diff[N-1] != a_reg[N-1]);
      end
      OP_CODE_SIZE'(OP_AND): alu_res = {1'b0, a_reg & b_reg};
      OP_CODE_SIZE'(OP_OR):  alu_res = {1'b0, a_reg | b_reg};
      OP_CODE_SIZE'(OP_XOR): alu_res = {1'b0, a_reg ^ b_reg};
      OP_CODE_SIZE'(OP_NOR): alu_res = {1'b0, ~(a_reg | b_reg)};
      OP_CODE_SIZE'(OP_SRA):
        alu_res = {1'b0, shift_big ? {N{a_reg[N-1]}} : N'($signed(a_reg) >>> b_reg)};
      OP_CODE_SIZE'(OP_SRL):
        alu_res = {1'b0, shift_big ? {N{1'b0}} : (a_reg >> b_reg)};
      default: alu_inv = 1'b1;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_reg <= S_A;
      a_reg     <= '0;
      b_reg     <= '0;
      res_reg   <= '0;
      zero_reg  <= 1'b0;
      ovf_reg   <= 1'b0;
      inv_reg   <= 1'b0;
      seq_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      a_reg     <= a_next;
      b_reg     <= b_next;
      res_reg   <= res_next;
      zero_reg  <= zero_next;
      ovf_reg   <= ovf_next;
      inv_reg   <= inv_next;
      seq_reg   <= seq_next;
    end
  end

  logic [2:0] match;
  logic       accept;
  logic       err;

  always_comb begin
    state_next = state_reg;
    a_next     = a_reg;
    b_next     = b_reg;
    res_next   = res_reg;
    zero_next  = zero_reg;
    ovf_next   = ovf_reg;
    inv_next   = inv_reg;
    seq_next   = seq_reg;

    case (state_reg)
      S_B:     match = 3'b010;
      S_OP:    match = 3'b100;
      default: match = 3'b001;
    endcase
    accept = |(press & match);
    err    = |(press & ~match);

    if (accept) begin
      case (state_reg)
        S_B: begin
          b_next     = i_switches;
          state_next = S_OP;
        end
        S_OP: begin
          res_next   = alu_res;
          zero_next  = (alu_res[N-1:0] == '0);
          ovf_next   = alu_ovf;
          inv_next   = alu_inv;
          state_next = S_RES;
        end
        default: begin
          a_next     = i_switches;
          state_next = S_B;
        end
      endcase
    end

    // A stray press in the same cycle as an accepted load keeps the error set.
    if (err) begin
      seq_next = 1'b1;
    end else if (accept) begin
      seq_next = 1'b0;
    end
  end

  assign o_resultado = res_reg;
  assign o_zero      = zero_reg;
  assign o_ovf       = ovf_reg;
  assign o_inv_op    = inv_reg;
  assign o_seq_err   = seq_reg;
  assign o_state     = state_reg;

endmodule

// File: tb/tb_alu_console.sv
module tb_alu_console;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] sw;
  logic       btn_a, btn_b, btn_op;
  logic [8:0] resultado;
  logic       zero, ovf, inv_op, seq_err;
  logic [1:0] state;

  always #5 clk = ~clk;

  alu_console #(
    .OPERAND_SIZE(8),
    .OP_CODE_SIZE(6),
    .DEBOUNCE_CYCLES(4)
  ) dut (
    .i_clk      (clk),
    .i_rst_n    (rst_n),
    .i_switches (sw),
    .i_btn_A    (btn_a),
    .i_btn_B    (btn_b),
    .i_btn_OP   (btn_op),
    .o_resultado(resultado),
    .o_zero     (zero),
    .o_ovf      (ovf),
    .o_inv_op   (inv_op),
    .o_seq_err  (seq_err),
    .o_state    (state)
  );

  typedef struct {
    string      name;
    logic [14:0] v;
  } exp_t;

  exp_t exp_q[$];
  event sample_ev;
  int   vectors = 0;
  int   miscompares = 0;
  int   direct_fails = 0;

  int m_a, m_b, m_st, m_res, m_zero, m_ovf, m_inv, m_seq;

  function automatic void model_reset();
    m_a = 0; m_b = 0; m_st = 0; m_res = 0;
    m_zero = 0; m_ovf = 0; m_inv = 0; m_seq = 0;
  endfunction

  function automatic logic [14:0] model_vec();
    return {2'(m_st), 9'(m_res), 1'(m_zero), 1'(m_ovf), 1'(m_inv), 1'(m_seq)};
  endfunction

  function automatic void model_compute(input int op);
    int sa, sb, r, t;
    sa = (m_a >= 128) ? m_a - 256 : m_a;
    sb = (m_b >= 128) ? m_b - 256 : m_b;
    r = 0; m_ovf = 0; m_inv = 0;
    case (op)
      'h20: begin r = m_a + m_b; t = sa + sb; m_ovf = (t > 127 || t < -128) ? 1 : 0; end
      'h22: begin
        r = (m_a - m_b + 256) % 256 + ((m_a < m_b) ? 256 : 0);
        t = sa - sb; m_ovf = (t > 127 || t < -128) ? 1 : 0;
      end
      'h24: r = m_a & m_b;
      'h25: r = m_a | m_b;
      'h26: r = m_a ^ m_b;
      'h27: r = (~(m_a | m_b)) & 255;
      'h03: r = (m_b >= 8) ? ((sa < 0) ? 255 : 0) : ((sa >>> m_b) & 255);
      'h02: r = (m_b >= 8) ? 0 : (m_a >> m_b);
      default: begin r = 0; m_inv = 1; end
    endcase
    m_res  = r;
    m_zero = ((r % 256) == 0) ? 1 : 0;
  endfunction

  function automatic void model_apply(input logic [2:0] mask, input logic [7:0] swv);
    int want;
    bit acc, bad;
    want = (m_st == 1) ? 1 : (m_st == 2) ? 2 : 0;
    acc  = mask[want];
    bad  = 1'b0;
    for (int k = 0; k < 3; k++) if (mask[k] && k != want) bad = 1'b1;
    if (acc) begin
      case (m_st)
        1: begin m_b = int'(swv); m_st = 2; end
        2: begin model_compute(int'(swv[5:0])); m_st = 3; end
        default: begin m_a = int'(swv); m_st = 1; end
      endcase
    end
    if (bad) m_seq = 1;
    else if (acc) m_seq = 0;
  endfunction

  task automatic push(input string name);
    exp_t e;
    e.name = name;
    e.v    = model_vec();
    exp_q.push_back(e);
    ->sample_ev;
  endtask

  task automatic check_zero_state(input string name);
    logic [14:0] act;
    act = {state, resultado, zero, ovf, inv_op, seq_err};
    if (act !== 15'd0) begin
      direct_fails++;
      $display("FAIL %s: outputs not cleared, got st=%0d res=%03h z=%0b ovf=%0b inv=%0b seq=%0b",
               name, act[14:13], act[12:4], act[3], act[2], act[1], act[0]);
    end else begin
      $display("ok   %s: all outputs 0, state S_A", name);
    end
  endtask

  initial begin
    exp_t e;
    logic [14:0] act;
    forever begin
      @(sample_ev);
      while (exp_q.size() > 0) begin
        e   = exp_q.pop_front();
        act = {state, resultado, zero, ovf, inv_op, seq_err};
        vectors++;
        if (act !== e.v) begin
          miscompares++;
          $display("FAIL %s: got st=%0d res=%03h z=%0b ovf=%0b inv=%0b seq=%0b, want st=%0d res=%03h z=%0b ovf=%0b inv=%0b seq=%0b",
                   e.name, act[14:13], act[12:4], act[3], act[2], act[1], act[0],
                   e.v[14:13], e.v[12:4], e.v[3], e.v[2], e.v[1], e.v[0]);
        end else begin
          $display("ok   %s: st=%0d res=%03h z=%0b ovf=%0b inv=%0b seq=%0b",
                   e.name, act[14:13], act[12:4], act[3], act[2], act[1], act[0]);
        end
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL timeout: wait expired after %0t, bench did not complete", $time);
    $finish;
  end

  task automatic press(input logic [2:0] mask, input logic [7:0] swv, input string name);
    @(negedge clk);
    sw = swv;
    {btn_op, btn_b, btn_a} = mask;
    repeat (6) @(negedge clk);
    push({name, "_early"});
    model_apply(mask, swv);
    @(negedge clk);
    push(name);
    repeat (3) @(negedge clk);
    {btn_op, btn_b, btn_a} = 3'b000;
    repeat (8) @(negedge clk);
    push({name, "_rel"});
  endtask

  task automatic glitch(input logic [2:0] mask, input int cycles, input string name);
    @(negedge clk);
    {btn_op, btn_b, btn_a} = mask;
    repeat (cycles) @(negedge clk);
    {btn_op, btn_b, btn_a} = 3'b000;
    repeat (12) @(negedge clk);
    push(name);
  endtask

  task automatic run_op(input logic [7:0] a, input logic [7:0] b, input logic [7:0] op, input string name);
    press(3'b001, a, {name, "_A"});
    press(3'b010, b, {name, "_B"});
    press(3'b100, op, name);
  endtask

  task automatic async_reset(input string name);
    @(negedge clk);
    #2 rst_n = 1'b0;
    {btn_op, btn_b, btn_a} = 3'b000;
    #1 model_reset();
    check_zero_state({name, "_immediate"});
    push(name);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  logic [5:0] ops[8] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h26, 6'h27, 6'h03, 6'h02};

  initial begin
    logic [2:0] mask;
    logic [7:0] swv;
    int want;
    rst_n = 1'b0;
    sw = 8'h00;
    {btn_op, btn_b, btn_a} = 3'b000;
    model_reset();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    check_zero_state("reset_state");
    push("reset");

    glitch(3'b001, 3, "glitch_A");
    press(3'b001, 8'hFF, "debounce_A");
    press(3'b010, 8'h01, "ldB");
    press(3'b100, 8'h20, "add_carry");

    run_op(8'h80, 8'h01, 8'h22, "sub_ovf");
    run_op(8'h01, 8'h02, 8'h22, "sub_borrow");
    run_op(8'h90, 8'h02, 8'h03, "sra2");
    run_op(8'h90, 8'h02, 8'h02, "srl2");
    run_op(8'h90, 8'h09, 8'h03, "sra9");
    run_op(8'h90, 8'h09, 8'h02, "srl9");
    run_op(8'h5A, 8'h0F, 8'h27, "nor");

    async_reset("rst_seq");
    press(3'b010, 8'h33, "seq_B_in_SA");
    press(3'b001, 8'h12, "seq_A_clear");
    press(3'b010, 8'h34, "seq_B");
    press(3'b100, 8'h3F, "inv_op");
    press(3'b101, 8'h07, "simul_A_OP");
    press(3'b010, 8'h05, "B_after_simul");
    press(3'b100, 8'h24, "and_clears_inv");

    press(3'b001, 8'h44, "mid_A");
    press(3'b010, 8'h55, "mid_B");
    async_reset("async_rst");
    press(3'b100, 8'h20, "op_after_rst");
    run_op(8'h7F, 8'h01, 8'h20, "add_ovf");

    for (int i = 0; i < 40; i++) begin
      want = (m_st == 1) ? 1 : (m_st == 2) ? 2 : 0;
      if ($urandom_range(0, 9) < 7) mask = 3'(1 << want);
      else mask = 3'($urandom_range(1, 7));
      swv = 8'($urandom);
      if (mask[1] && $urandom_range(0, 2) == 0) swv = 8'($urandom_range(0, 9));
      if (mask[2] && $urandom_range(0, 3) != 0) swv[5:0] = ops[$urandom_range(0, 7)];
      press(mask, swv, $sformatf("rnd%0d_m%0d_sw%02h", i, mask, swv));
    end

    repeat (2) @(negedge clk);
    if (miscompares != 0 || direct_fails != 0)
      $display("FAIL == %0d vectors applied, %0d miscompares, %0d direct failures ==",
               vectors, miscompares, direct_fails);
    else
      $display("PASS == %0d vectors applied, 0 miscompares ==", vectors);
    $finish;
  end

endmodule

// File: doc/alu_console.md
Name: alu_console

Overview:
- Parametrised successor to the board-level ALU wrapper. It conditions the three push-buttons and sequences operand and opcode loading through an FSM.
- It computes a registered result with status flags, so the LEDs show a stable value. Glitchy raw button levels never drive the datapath.
- It sits between the board pins (switches, buttons, LEDs) and nothing else. The ALU datapath is internal.

Parameters:
- OPERAND_SIZE, 8, width of operands A/B and switch bus.
- OP_CODE_SIZE, 6, opcode width taken from sw[OP_CODE_SIZE-1:0] (requires OP_CODE_SIZE <= OPERAND_SIZE).
- DEBOUNCE_CYCLES, 1000000, consecutive stable cycles required before a button level is accepted (10 ms at 100 MHz).

Ports:
- i_clk  in  1  system clock
- i_rst_n  in  1  asynchronous active-low reset
- i_switches  in  OPERAND_SIZE  operand/opcode source
- i_btn_A  in  1  raw button, load A
- i_btn_B  in  1  raw button, load B
- i_btn_OP  in  1  raw button, load opcode and compute
- o_resultado  out  OPERAND_SIZE+1  registered result; MSB = carry/borrow
- o_zero  out  1  result[OPERAND_SIZE-1:0]==0
- o_ovf  out  1  signed overflow (ADD/SUB only)
- o_inv_op  out  1  last opcode unsupported
- o_seq_err  out  1  sticky out-of-order button press
- o_state  out  2  FSM state for LEDs

Behaviour:
- Reset (async, i_rst_n low):
  - A, B and OP registers = 0; all outputs = 0.
  - State = S_A (encoding 0).
  - Conditioner counters and stable levels = 0.
  - Reset mid-sequence discards the partial load.
- Button conditioning, per button:
  - 2-FF synchroniser, then debounce counter.
  - The stable level takes the synced value after it has differed from the stable level for DEBOUNCE_CYCLES consecutive cycles. Any bounce restarts the count.
  - A one-cycle pulse fires on each stable rising edge.
  - Raw high at edge t gives a pulse at edge t+2+DEBOUNCE_CYCLES. Releases produce no pulse.
- FSM states and encodings: S_A=0, S_B=1, S_OP=2, S_RES=3.
  - S_A: pA pulse loads A <- i_switches; go to S_B.
  - S_B: pB pulse loads B; go to S_OP.
  - S_OP: pOP pulse loads OP <- i_switches[OP_CODE_SIZE-1:0]; result, flags and o_inv_op are written on the same edge; go to S_RES.
  - S_RES: outputs held. pA loads a new A and goes to S_B; result stays displayed until the next pOP.
- Out-of-order pulses:
  - Any pulse not matching the current state (pA counts as matching in S_A and S_RES) is ignored and sets o_seq_err.
  - o_seq_err clears on the next accepted load, unless a non-matching pulse occurs in the same cycle; set wins.
  - With simultaneous pulses, the matching pulse is accepted and the others raise the error.
- Arithmetic uses N = OPERAND_SIZE. Result is {c, r[N-1:0]}.
  - ADD 100000: {c,r} = A+B (N+1-bit); ovf = signed overflow.
  - SUB 100010: r = A-B; c = borrow (A<B unsigned); ovf = signed overflow.
  - AND 100100, OR 100101, XOR 100110, NOR 100111: bitwise; c=0.
  - SRA 000011: A arithmetic-shifted right by B. If B>=N, result is all sign bits.
  - SRL 000010: logical shift right. If B>=N, r=0.
  - c=0 and ovf=0 for all non-ADD/SUB ops.
  - Any other opcode: r=0, c=0, ovf=0, o_inv_op=1. A supported opcode clears o_inv_op.
  - o_zero is computed from r only.
- Latency: one clock from the accepted pOP pulse to updated o_resultado. Outputs are registered, with no combinational path from pins.

Decomposition:
- Package alu_console_pkg:
  - opcode localparams (OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_NOR, OP_SRA, OP_SRL);
  - state encodings S_A..S_RES.
- Sub-module btn_conditioner (params DEBOUNCE_CYCLES; ports i_clk, i_rst_n, i_btn, o_level, o_pulse), instantiated three times.
- FSM and datapath live in alu_console. Counter width is $clog2(DEBOUNCE_CYCLES+1).

Test Plan:
- All benches use DEBOUNCE_CYCLES=4 and N=8.
- Debounce: press btn_A high 3 cycles, low, then high 10 cycles → exactly one pA, at edge t+6 of the stable press. The 3-cycle glitch produces no pulse.
- ADD carry: A=0xFF, B=0x01, OP=0x20 → o_resultado=0x100, o_zero=1, o_ovf=0, o_state=3, one cycle after pOP.
- SUB signed overflow: A=0x80, B=0x01, OP=0x22 → o_resultado=0x07F, o_ovf=1, borrow c=0. With A=0x01, B=0x02 → 0x1FF, c=1, ovf=0.
- Shifts: A=0x90, B=2, SRA → 0xE4 and SRL → 0x24. With B=9: SRA → 0xFF, SRL → 0x00 (o_zero=1).
- Sequencing: in S_A press B → o_seq_err=1, state stays 0. Then press A → seq_err=0, state=1. Opcode 0x3F → o_inv_op=1, result 0.
- Reset mid-operation: after A and B are loaded, pull i_rst_n low asynchronously → all outputs 0 and state 0 immediately. Releasing it requires a full A/B/OP sequence again.
